timer_mc: RTL

Multi-channel, width-parametrised successor to the single-channel MIPS system timer. It provides NCH independent down-counters on the processor's device bus, each with its own CTRL/PRESET/COUNT registers and a one-shot, auto-reload or free-running mode. Each channel has a pending flag that the processor clears by writing 1, and all channels drive one shared interrupt line to the CP0 interrupt input. The bus protocol is unchanged: word address, single-cycle write strobe, combinational read.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_channel.sv | 138 +++++++++++++
 rtl/timer_mc.sv | 82 ++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel timer: register selects, mode
// encodings and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ADD_CTRL   = 2'd0,
    ADD_PRESET = 2'd1,
    ADD_COUNT  = 2'd2,
    ADD_STATUS = 2'd3
  } reg_sel_e;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_FREE    = 2'b10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 8;
  localparam int CTRL_PSC_HI  = 15;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT registers, tick generation and the
// pending-set pulse. Optional 8-bit prescaler under TIMER_PRESCALE_EN.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_we_i,
  input  logic             preset_we_i,
  input  logic             count_we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      ctrl_o,
  output logic [WIDTH-1:0] preset_o,
  output logic [WIDTH-1:0] count_o,
  output logic             set_pend_o
);

  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick;
  logic             any_we;
  logic [7:0]       psc_rd;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign any_we       = ctrl_we_i | preset_we_i | count_we_i;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc_q, psc_d;
  logic [7:0] pcnt_q, pcnt_d;

  always_comb begin
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    if (ctrl_we_i) begin
      psc_d  = wdata_i[CTRL_PSC_HI:CTRL_PSC_LO];
      pcnt_d = wdata_i[CTRL_PSC_HI:CTRL_PSC_LO];
    end else if (en_q) begin
      pcnt_d = (pcnt_q == 8'd0) ? psc_q : pcnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q  <= 8'd0;
      pcnt_q <= 8'd0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign tick   = en_q && (pcnt_q == 8'd0);
  assign psc_rd = psc_q;
`else
  assign tick   = en_q;
  assign psc_rd = 8'd0;
`endif

  // CPU writes take priority; a tick coinciding with any write is dropped
  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    set_pend_o = 1'b0;
    if (ctrl_we_i) begin
      en_d   = wdata_i[CTRL_EN];
      mode_d = wdata_i[CTRL_MODE_HI:CTRL_MODE_LO];
      im_d   = wdata_i[CTRL_IM];
    end
    if (preset_we_i) begin
      preset_d = wdata_i[WIDTH-1:0];
      count_d  = wdata_i[WIDTH-1:0];
    end
    if (count_we_i) begin
      count_d = wdata_i[WIDTH-1:0];
    end
    if (tick && !any_we) begin
      case (mode_q)
        MODE_RELOAD: begin
          if (count_q == WIDTH'(1)) begin
            count_d    = '0;
            set_pend_o = 1'b1;
          end else if (count_q == '0) begin
            count_d = preset_q;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        MODE_FREE: begin
          if (count_q == '1) begin
            count_d    = '0;
            set_pend_o = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: begin
          if (count_q == WIDTH'(1)) begin
            count_d    = '0;
            set_pend_o = 1'b1;
            en_d       = 1'b0;
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  assign ctrl_o   = {16'd0, psc_rd, 4'd0, im_q, mode_q, en_q};
  assign preset_o = preset_q;
  assign count_o  = count_q;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel device-bus timer: address decode, shared pending/W1C,
// read mux and irq. Define TIMER_PRESCALE_EN to enable per-channel prescalers.
module timer_mc
  import timer_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:2]  add,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  reg_sel_e         sel;
  logic [1:0]       ch;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   set_pend;
  logic [NCH-1:0]   im_vec;
  logic [NCH-1:0]   w1c;
  logic [31:0]      ctrl_rd   [NCH];
  logic [WIDTH-1:0] preset_rd [NCH];
  logic [WIDTH-1:0] count_rd  [NCH];

  assign sel = reg_sel_e'(add[3:2]);
  assign ch  = add[5:4];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic ch_we;
    assign ch_we = we && (int'(ch) == g);

    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .ctrl_we_i  (ch_we && (sel == ADD_CTRL)),
      .preset_we_i(ch_we && (sel == ADD_PRESET)),
      .count_we_i (ch_we && (sel == ADD_COUNT)),
      .wdata_i    (din),
      .ctrl_o     (ctrl_rd[g]),
      .preset_o   (preset_rd[g]),
      .count_o    (count_rd[g]),
      .set_pend_o (set_pend[g])
    );

    assign im_vec[g] = ctrl_rd[g][CTRL_IM];
  end

  // STATUS is timer-wide; a fresh pending-set wins over a same-cycle clear
  assign w1c    = (we && (sel == ADD_STATUS)) ? din[NCH-1:0] : '0;
  assign pend_d = (pend_q & ~w1c) | set_pend;

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign irq = |(pend_q & im_vec);

  always_comb begin
    dout = '0;
    if (sel == ADD_STATUS) begin
      dout = 32'(pend_q);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(ch) == i) begin
          case (sel)
            ADD_CTRL:   dout = ctrl_rd[i];
            ADD_PRESET: dout = 32'(preset_rd[i]);
            ADD_COUNT:  dout = 32'(count_rd[i]);
            default:    dout = '0;
          endcase
        end
      end
    end
  end

endmodule
